// File: rtl/bomb_pkg.sv
// Shared types and helpers for the bomb game's password stage.
// Holds the verifier state enum, keypad control codes, and the code-digit
// derivation used by both the verifier and the password display.
package bomb_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ENTRY,
      ST_CHECK,
      ST_SUCCESS,
      ST_FAIL
   } state_e;

   localparam logic [3:0] KEY_CLEAR = 4'hE;
   localparam logic [3:0] KEY_ENTER = 4'hF;

   // Digit k of the code: (seed + 3k) mod 10; 6-bit sum covers 31 + 9.
   function automatic logic [3:0] code_digit(input logic [4:0] seed, input logic [1:0] k);
      logic [5:0] sum;
      sum = 6'(seed) + 6'(k) * 6'd3;
      return 4'(sum % 6'd10);
   endfunction

endpackage

// File: rtl/hold_timer.sv
// Loadable down-counter that emits a one-cycle done pulse on expiry.
// Ports: clk, Rst (sync, active-low), load / load_val (start a count),
//        done_c (combinational, high for one cycle when the count hits 0).
module hold_timer #(
   parameter int unsigned CW = 8
) (
   input  logic          clk,
   input  logic          Rst,
   input  logic          load,
   input  logic [CW-1:0] load_val,
   output logic          done_c
);

   logic [CW-1:0] count;
   logic          busy;

   // Count down from load_val to zero once, then go idle.
   always_ff @(posedge clk) begin
      if (!Rst) begin
         count <= '0;
         busy  <= 1'b0;
      end else if (load) begin
         count <= load_val;
         busy  <= 1'b1;
      end else if (busy) begin
         if (count == '0) busy  <= 1'b0;
         else             count <= count - CW'(1);
      end
   end

   assign done_c = busy && (count == '0) && !load;

endmodule

// File: rtl/code_verify.sv
// Password entry and verification stage behind the game controller.
// Latches the seed on start_input rising, collects keypad digits, checks
// attempts against the derived code, holds success/fail for HOLD_CYCLES and
// then pulses repeat_rst for one cycle.
// Ports: clk, Rst (sync, active-low); start_input, seed, timeout, key_valid,
//        key_code in; success, fail, repeat_rst, entry, digits_entered,
//        tries_left out (all registered).
module code_verify
   import bomb_pkg::*;
#(
   parameter int unsigned CODE_DIGITS = 4,
   parameter int unsigned MAX_TRIES   = 3,
   parameter int unsigned HOLD_CYCLES = 150_000_000
) (
   input  logic                     clk,
   input  logic                     Rst,
   input  logic                     start_input,
   input  logic [4:0]               seed,
   input  logic                     timeout,
   input  logic                     key_valid,
   input  logic [3:0]               key_code,
   output logic                     success,
   output logic                     fail,
   output logic                     repeat_rst,
   output logic [4*CODE_DIGITS-1:0] entry,
   output logic [2:0]               digits_entered,
   output logic [1:0]               tries_left
);

   localparam int unsigned ENTRY_W = 4 * CODE_DIGITS;
   localparam int unsigned CW      = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1;

   state_e               state, state_nxt;
   logic                 start_q;
   logic [4:0]           seed_q, seed_nxt;
   logic [ENTRY_W-1:0]   entry_nxt, code;
   logic [2:0]           digits_nxt;
   logic [1:0]           tries_nxt;
   logic                 success_nxt, fail_nxt, repeat_nxt;
   logic                 hold_load_c, hold_done_c;
   logic                 start_rise, start_fall;
   logic                 to_idle, to_fail, to_success;

   assign start_rise = start_input && !start_q;
   assign start_fall = !start_input && start_q;

   // Code is always derived from the latched seed, first digit in the top nibble.
   always_comb begin
      code = '0;
      for (int i = 0; i < CODE_DIGITS; i++)
         code[ENTRY_W-1-4*i -: 4] = code_digit(seed_q, 2'(i));
   end

   hold_timer #(.CW(CW)) u_hold (
      .clk      (clk),
      .Rst      (Rst),
      .load     (hold_load_c),
      .load_val (CW'(HOLD_CYCLES - 2)),
      .done_c   (hold_done_c)
   );

   // Next-state and next-output logic.
   always_comb begin
      state_nxt   = state;
      seed_nxt    = seed_q;
      entry_nxt   = entry;
      digits_nxt  = digits_entered;
      tries_nxt   = tries_left;
      success_nxt = success;
      fail_nxt    = fail;
      repeat_nxt  = 1'b0;
      hold_load_c = 1'b0;
      to_idle     = 1'b0;
      to_fail     = 1'b0;
      to_success  = 1'b0;

      // Losing the enable aborts everything without a restart pulse.
      if (state != ST_IDLE && start_fall) begin
         to_idle = 1'b1;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start_rise) begin
                  seed_nxt  = seed;
                  state_nxt = ST_ENTRY;
               end
            end
            ST_ENTRY: begin
               if (timeout) begin
                  to_fail = 1'b1;
               end else if (key_valid) begin
                  if (key_code <= 4'd9) begin
                     if (digits_entered < 3'(CODE_DIGITS)) begin
                        for (int i = 0; i < CODE_DIGITS; i++)
                           if (digits_entered == 3'(i))
                              entry_nxt[ENTRY_W-1-4*i -: 4] = key_code;
                        digits_nxt = digits_entered + 3'd1;
                     end
                  end else if (key_code == KEY_CLEAR) begin
                     entry_nxt  = '1;
                     digits_nxt = 3'd0;
                  end else if (key_code == KEY_ENTER) begin
                     state_nxt = ST_CHECK;
                  end
               end
            end
            ST_CHECK: begin
               if (timeout) begin
                  to_fail = 1'b1;
               end else if (digits_entered == 3'(CODE_DIGITS) && entry == code) begin
                  to_success = 1'b1;
               end else begin
                  tries_nxt = tries_left - 2'd1;
                  if (tries_left <= 2'd1) begin
                     to_fail = 1'b1;
                  end else begin
                     entry_nxt  = '1;
                     digits_nxt = 3'd0;
                     state_nxt  = ST_ENTRY;
                  end
               end
            end
            ST_SUCCESS, ST_FAIL: begin
               // repeat_rst marks the last hold cycle; leave on the following edge.
               if (repeat_rst) to_idle = 1'b1;
               else            repeat_nxt = hold_done_c;
            end
            default: to_idle = 1'b1;
         endcase
      end

      if (to_fail) begin
         state_nxt   = ST_FAIL;
         fail_nxt    = 1'b1;
         success_nxt = 1'b0;
         hold_load_c = 1'b1;
      end
      if (to_success) begin
         state_nxt   = ST_SUCCESS;
         success_nxt = 1'b1;
         fail_nxt    = 1'b0;
         hold_load_c = 1'b1;
      end
      if (to_idle) begin
         state_nxt   = ST_IDLE;
         entry_nxt   = '1;
         digits_nxt  = 3'd0;
         tries_nxt   = 2'(MAX_TRIES);
         success_nxt = 1'b0;
         fail_nxt    = 1'b0;
         repeat_nxt  = 1'b0;
      end
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (!Rst) begin
         state          <= ST_IDLE;
         start_q        <= 1'b0;
         seed_q         <= '0;
         entry          <= '1;
         digits_entered <= 3'd0;
         tries_left     <= 2'(MAX_TRIES);
         success        <= 1'b0;
         fail           <= 1'b0;
         repeat_rst     <= 1'b0;
      end else begin
         state          <= state_nxt;
         start_q        <= start_input;
         seed_q         <= seed_nxt;
         entry          <= entry_nxt;
         digits_entered <= digits_nxt;
         tries_left     <= tries_nxt;
         success        <= success_nxt;
         fail           <= fail_nxt;
         repeat_rst     <= repeat_nxt;
      end
   end

endmodule

// File: tb/tb_code_verify.sv
// Self-checking bench for code_verify: scoreboard of expected output changes
// (value + cycle) fed by a game-level model, checked by a negedge monitor.
module tb_code_verify;

   localparam int unsigned H = 16;
   localparam logic [23:0] IDLE_T = {3'b000, 16'hFFFF, 3'd0, 2'd3};

   logic        clk = 1'b0, Rst = 1'b0, start_input = 1'b0, timeout = 1'b0, key_valid = 1'b0;
   logic [4:0]  seed = '0;
   logic [3:0]  key_code = '0;
   logic        success, fail, repeat_rst;
   logic [15:0] entry;
   logic [2:0]  digits_entered;
   logic [1:0]  tries_left;

   code_verify #(.HOLD_CYCLES(H)) dut (
      .clk(clk), .Rst(Rst), .start_input(start_input), .seed(seed), .timeout(timeout),
      .key_valid(key_valid), .key_code(key_code), .success(success), .fail(fail),
      .repeat_rst(repeat_rst), .entry(entry), .digits_entered(digits_entered),
      .tries_left(tries_left)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int total = 0, bad = 0;

   typedef struct { int cyc; logic [23:0] val; } exp_t;
   exp_t        q[$];
   exp_t        it;
   logic [23:0] cur_exp = IDLE_T, last_seen = IDLE_T, now_v;
   bit          mon_en = 1'b0;

   // Game-level model.
   int m_code[4];
   int m_digs[$];
   int m_tries = 3;
   bit m_entry = 0, m_hold = 0, m_succ = 0, m_fail = 0;
   int m_hold_t = 0;

   function automatic logic [23:0] mk(bit s, bit f, bit r);
      logic [15:0] e;
      e = 16'hFFFF;
      for (int i = 0; i < m_digs.size(); i++) e[15-4*i -: 4] = 4'(m_digs[i]);
      return {s, f, r, e, 3'(m_digs.size()), 2'(m_tries)};
   endfunction

   function automatic void expect_at(int t, logic [23:0] v);
      if (v !== cur_exp) begin
         q.push_back('{cyc: t, val: v});
         cur_exp = v;
      end
   endfunction

   function automatic void go_idle_model();
      m_digs.delete();
      m_tries = 3;
      m_succ = 0; m_fail = 0; m_entry = 0; m_hold = 0;
   endfunction

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic start_game(input logic [4:0] s, input bit with_key);
      start_input = 1'b1;
      seed = s;
      if (with_key) begin key_valid = 1'b1; key_code = 4'($urandom_range(0, 9)); end
      for (int k = 0; k < 4; k++) m_code[k] = (int'(s) + 3 * k) % 10;
      m_digs.delete(); m_tries = 3; m_entry = 1;
      tick();
      key_valid = 1'b0;
   endtask

   task automatic press(input logic [3:0] k, input bit to);
      int e;
      bit is_enter, ok;
      e = cyc + 1;
      is_enter = 0;
      key_valid = 1'b1; key_code = k; timeout = to;
      if (m_entry) begin
         if (to) begin
            m_entry = 0; m_fail = 1; m_hold = 1; m_hold_t = e;
            expect_at(e, mk(0, 1, 0));
         end else if (k <= 4'd9) begin
            if (m_digs.size() < 4) begin
               m_digs.push_back(int'(k));
               expect_at(e, mk(0, 0, 0));
            end
         end else if (k == 4'hE) begin
            m_digs.delete();
            expect_at(e, mk(0, 0, 0));
         end else if (k == 4'hF) begin
            is_enter = 1; m_entry = 0;
            ok = (m_digs.size() == 4);
            for (int i = 0; i < m_digs.size(); i++) if (m_digs[i] != m_code[i]) ok = 0;
            if (ok) begin
               m_succ = 1; m_hold = 1; m_hold_t = e + 1;
               expect_at(e + 1, mk(1, 0, 0));
            end else begin
               m_tries--;
               if (m_tries == 0) begin
                  m_fail = 1; m_hold = 1; m_hold_t = e + 1;
                  expect_at(e + 1, mk(0, 1, 0));
               end else begin
                  m_digs.delete(); m_entry = 1;
                  expect_at(e + 1, mk(0, 0, 0));
               end
            end
         end
      end
      tick();
      key_valid = 1'b0; timeout = 1'b0;
      if (is_enter) tick();
   endtask

   task automatic wait_idle();
      int t;
      if (m_hold) begin
         t = m_hold_t;
         expect_at(t + H - 1, mk(m_succ, m_fail, 1));
         go_idle_model();
         expect_at(t + H, mk(0, 0, 0));
         while (cyc < t + H) tick();
      end
   endtask

   task automatic stop_game();
      int e;
      e = cyc + 1;
      start_input = 1'b0;
      go_idle_model();
      expect_at(e, mk(0, 0, 0));
      tick();
   endtask

   task automatic do_reset();
      int e;
      e = cyc + 1;
      Rst = 1'b0; start_input = 1'b0;
      go_idle_model();
      expect_at(e, mk(0, 0, 0));
      tick();
      Rst = 1'b1;
   endtask

   task automatic press_seq(input int n, input logic [15:0] ks);
      logic [15:0] v;
      v = ks;
      for (int i = 0; i < n; i++) press(v[15-4*i -: 4], 1'b0);
   endtask

   // Monitor: every observed output change must match the next expected change.
   always @(negedge clk) begin
      if (mon_en) begin
         now_v = {success, fail, repeat_rst, entry, digits_entered, tries_left};
         if (now_v !== last_seen) begin
            total++;
            if (q.size() == 0) begin
               bad++;
               $display("FAIL unexpected_change cyc=%0d got=%h", cyc, now_v);
            end else begin
               it = q.pop_front();
               if (it.val !== now_v || it.cyc != cyc) begin
                  bad++;
                  $display("FAIL out_change cyc=%0d got=%h required=%h at cyc=%0d",
                           cyc, now_v, it.val, it.cyc);
               end
            end
            last_seen = now_v;
         end else if (q.size() != 0 && q[0].cyc <= cyc) begin
            total++; bad++;
            it = q.pop_front();
            $display("FAIL missed_change cyc=%0d got=%h required=%h at cyc=%0d",
                     cyc, now_v, it.val, it.cyc);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired cyc=%0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      Rst = 1'b0;
      repeat (3) @(posedge clk);
      #1 Rst = 1'b1;
      @(negedge clk);
      total++;
      if ({success, fail, repeat_rst, entry, digits_entered, tries_left} !== IDLE_T) begin
         bad++;
         $display("FAIL reset_state got=%h required=%h",
                  {success, fail, repeat_rst, entry, digits_entered, tries_left}, IDLE_T);
      end
      tick();
      last_seen = IDLE_T;
      mon_en = 1'b1;

      // seed 5 -> code 5814, correct entry, full hold and restart pulse
      start_game(5'd5, 1'b1);
      press_seq(5, 16'h581F);
      press(4'hF, 1'b0);
      wait_idle();
      stop_game();

      // seed 31 -> code 1470, three wrong attempts, keys ignored in FAIL
      start_game(5'd31, 1'b0);
      for (int a = 0; a < 3; a++) press_seq(5, 16'h000F);
      press_seq(4, 16'h1470);
      press(4'hF, 1'b0);
      wait_idle();
      stop_game();

      // clear, overflow digit ignored, then success
      start_game(5'd31, 1'b0);
      press_seq(3, 16'h14E0);
      press_seq(4, 16'h1470);
      press(4'h9, 1'b0);
      press(4'hF, 1'b0);
      wait_idle();
      stop_game();

      // timeout beats a correct enter in the same cycle
      start_game(5'd12, 1'b0);
      for (int k = 0; k < 4; k++) press(4'(m_code[k]), 1'b0);
      press(4'hF, 1'b1);
      wait_idle();
      stop_game();

      // enter after 3 digits counts as a wrong attempt
      start_game(5'd5, 1'b0);
      press_seq(4, 16'h581F);
      stop_game();

      // reset mid-hold: no restart pulse afterwards
      start_game(5'd5, 1'b0);
      press_seq(4, 16'h5814);
      press(4'hF, 1'b0);
      repeat (3) tick();
      do_reset();
      repeat (20) tick();

      // start_input falling in ENTRY
      start_game(5'd9, 1'b0);
      press_seq(2, 16'h3300);
      stop_game();

      // randomized games
      for (int g = 0; g < 30; g++) begin
         start_game(5'($urandom_range(0, 31)), ($urandom_range(0, 3) == 0));
         for (int a = 0; a < 40 && m_entry; a++) begin
            int r;
            logic [3:0] k;
            r = $urandom_range(0, 99);
            if (r < 55)      k = (m_digs.size() < 4) ? 4'(m_code[m_digs.size()]) : 4'hF;
            else if (r < 68) k = 4'($urandom_range(0, 9));
            else if (r < 74) k = 4'hE;
            else if (r < 90) k = 4'hF;
            else if (r < 95) k = 4'($urandom_range(10, 13));
            else             k = 4'($urandom_range(0, 15));
            press(k, r >= 97);
            if ($urandom_range(0, 3) == 0) tick();
         end
         if (m_hold && $urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(0, 6)) tick();
            stop_game();
         end else begin
            wait_idle();
            stop_game();
         end
         tick();
      end

      repeat (5) tick();
      total++;
      if (q.size() != 0) begin
         bad++;
         $display("FAIL pending_expectations got=%0d required=0", q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
